// File: rtl/doa_filter_pkg.sv
// doa_filter_pkg
//   Shared definitions for the DOA smoothing filter:
//   - state_t   : filter occupancy state (EMPTY, FILL, LOCKED)
//   - DOA_MIN/MAX : legal DOA range in degrees
//   - SEG_*     : active-low 7-segment patterns, bit order {g,f,e,d,c,b,a}
package doa_filter_pkg;

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        FILL   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam int DOA_MIN = -90;
    localparam int DOA_MAX = 90;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_MINUS = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/doa_filter_seg7_digit.sv
// seg7_digit
//   Decimal digit to active-low 7-segment pattern ({g,f,e,d,c,b,a}).
//   Only built when DOA_FILTER_SEG_EN is defined, since the display path
//   is the sole user.
//   Ports:
//     digit : in  4  decimal digit 0..9 (other codes show blank)
//     seg   : out 7  active-low segment pattern
`ifdef DOA_FILTER_SEG_EN
module seg7_digit
    import doa_filter_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule
`endif

// File: rtl/doa_filter.sv
// doa_filter
//   Temporal smoothing of the per-frame DOA estimate: moving average over
//   DEPTH accepted frames with range rejection, outlier rejection while
//   LOCKED, and a flush/re-seed after REJ_LIMIT consecutive outliers.
//   Two-stage pipeline: S1 registers the sample and decides accept/reject,
//   S2 updates window/sum/pointer and the output; out_valid follows
//   in_valid by two cycles.
//   Optional build macro DOA_FILTER_SEG_EN adds registered 7-segment outputs.
//   Ports:
//     clk        : in  1  system clock
//     rst_n      : in  1  synchronous active-low reset
//     in_valid   : in  1  doa_in strobe
//     doa_in     : in  8  signed DOA estimate
//     clear      : in  1  synchronous flush (priority over in_valid)
//     out_valid  : out 1  doa_avg / flags updated
//     doa_avg    : out 8  signed smoothed DOA
//     sample_rej : out 1  last sample rejected (qualified by out_valid)
//     locked     : out 1  window full
//     fill_cnt   : out clog2(DEPTH)+1  valid window entries
//     reject_cnt : out 8  total rejections, saturating
//     seg2/1/0   : out 7  sign, tens, ones (DOA_FILTER_SEG_EN only)
module doa_filter
    import doa_filter_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int MAX_STEP  = 30,
    parameter int REJ_LIMIT = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic signed [7:0]       doa_in,
    input  logic                    clear,
    output logic                    out_valid,
    output logic signed [7:0]       doa_avg,
    output logic                    sample_rej,
    output logic                    locked,
    output logic [$clog2(DEPTH):0]  fill_cnt,
    output logic [7:0]              reject_cnt
`ifdef DOA_FILTER_SEG_EN
    ,
    output logic [6:0]              seg2,
    output logic [6:0]              seg1,
    output logic [6:0]              seg0
`endif
);

    localparam int LOG_D = $clog2(DEPTH);
    localparam int SUM_W = 8 + LOG_D;
    localparam int CNT_W = LOG_D + 1;
    localparam int CON_W = $clog2(REJ_LIMIT + 1);
    localparam logic signed [7:0] LO = 8'(DOA_MIN);
    localparam logic signed [7:0] HI = 8'(DOA_MAX);

    // Round-half-up divide by DEPTH; floor semantics for negative sums.
    function automatic logic signed [7:0] round_avg(input logic signed [SUM_W-1:0] s);
        logic signed [SUM_W:0] t;
        t = (SUM_W+1)'(s) + (SUM_W+1)'(DEPTH / 2);
        t = t >>> LOG_D;
        return t[7:0];
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] c);
        return (c == 8'hFF) ? c : c + 8'd1;
    endfunction

    state_t                   state;
    logic                     vld_p1;
    logic signed [7:0]        doa_p1;
    logic [LOG_D-1:0]         ptr;
    logic signed [SUM_W-1:0]  sum;
    logic [CON_W-1:0]         consec;
    logic signed [7:0]        win [DEPTH];

    logic                     take;
    logic signed [8:0]        diff;
    logic signed [8:0]        dmag;
    logic                     out_range;
    logic                     outlier;
    logic                     do_flush;
    logic                     do_rej;
    logic signed [7:0]        oldest;
    logic signed [SUM_W-1:0]  sum_acc;
    logic [CNT_W-1:0]         fill_nxt;

    // A new sample is only taken when both stages are empty.
    assign take   = in_valid && !vld_p1 && !out_valid && !clear;
    assign locked = (state == LOCKED);

    // ---- S0 -> S1: capture sample ----
    always_ff @(posedge clk) begin
        if (take) begin
            doa_p1 <= doa_in;
        end
    end

    // S1 decision, evaluated against the state left by the previous sample.
    always_comb begin
        diff      = 9'(doa_p1) - 9'(doa_avg);
        dmag      = diff[8] ? -diff : diff;
        out_range = (doa_p1 < LO) || (doa_p1 > HI);
        outlier   = (state == LOCKED) && (dmag > 9'(MAX_STEP));
        do_flush  = !out_range && outlier && (consec == CON_W'(REJ_LIMIT - 1));
        do_rej    = out_range || (outlier && !do_flush);
        oldest    = (state == LOCKED) ? win[ptr] : 8'sd0;
        sum_acc   = sum + SUM_W'(doa_p1) - SUM_W'(oldest);
        fill_nxt  = (fill_cnt == CNT_W'(DEPTH)) ? fill_cnt : fill_cnt + CNT_W'(1);
    end

    // ---- S1 -> S2: window storage (data only, never read before written) ----
    always_ff @(posedge clk) begin
        if (rst_n && !clear && vld_p1 && !do_rej) begin
            win[do_flush ? LOG_D'(0) : ptr] <= doa_p1;
        end
    end

    // ---- S1 -> S2: control, sum and outputs ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1     <= 1'b0;
            out_valid  <= 1'b0;
            doa_avg    <= '0;
            sample_rej <= 1'b0;
            state      <= EMPTY;
            fill_cnt   <= '0;
            reject_cnt <= '0;
            ptr        <= '0;
            sum        <= '0;
            consec     <= '0;
        end else if (clear) begin
            vld_p1    <= 1'b0;
            out_valid <= 1'b0;
            doa_avg   <= '0;
            state     <= EMPTY;
            fill_cnt  <= '0;
            ptr       <= '0;
            sum       <= '0;
            consec    <= '0;
        end else begin
            vld_p1    <= take;
            out_valid <= vld_p1;
            if (vld_p1) begin
                if (do_flush) begin
                    sum        <= SUM_W'(doa_p1);
                    fill_cnt   <= CNT_W'(1);
                    ptr        <= LOG_D'(1);
                    state      <= FILL;
                    doa_avg    <= doa_p1;
                    sample_rej <= 1'b0;
                    consec     <= '0;
                end else if (do_rej) begin
                    reject_cnt <= sat_inc8(reject_cnt);
                    sample_rej <= 1'b1;
                    // Range rejects do not count toward the re-seed limit.
                    if (!out_range) begin
                        consec <= consec + CON_W'(1);
                    end
                end else begin
                    sum        <= sum_acc;
                    ptr        <= ptr + LOG_D'(1);
                    fill_cnt   <= fill_nxt;
                    consec     <= '0;
                    sample_rej <= 1'b0;
                    if (fill_nxt == CNT_W'(DEPTH)) begin
                        state   <= LOCKED;
                        doa_avg <= round_avg(sum_acc);
                    end else begin
                        state   <= FILL;
                        doa_avg <= doa_p1;
                    end
                end
            end
        end
    end

`ifdef DOA_FILTER_SEG_EN
    logic [7:0] mag;
    logic [3:0] tens;
    logic [3:0] ones;
    logic [6:0] pat1;
    logic [6:0] pat0;

    assign mag  = doa_avg[7] ? 8'(-doa_avg) : 8'(doa_avg);
    assign tens = 4'(mag / 8'd10);
    assign ones = 4'(mag % 8'd10);

    seg7_digit u_tens (.digit(tens), .seg(pat1));
    seg7_digit u_ones (.digit(ones), .seg(pat0));

    // ---- S2 -> S3: display registers ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg2 <= SEG_BLANK;
            seg1 <= SEG_BLANK;
            seg0 <= SEG_BLANK;
        end else if (out_valid) begin
            seg2 <= doa_avg[7] ? SEG_MINUS : SEG_BLANK;
            seg1 <= pat1;
            seg0 <= pat0;
        end
    end
`endif

endmodule

// File: tb/tb_doa_filter.sv
// tb_doa_filter
//   Randomized and directed stimulus for doa_filter, checked against a
//   queue-based reference of the filter rules.
module tb_doa_filter;

    localparam int DEPTH     = 8;
    localparam int MAX_STEP  = 30;
    localparam int REJ_LIMIT = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic signed [7:0] doa_in = '0;
    logic              clear = 1'b0;
    logic              out_valid;
    logic signed [7:0] doa_avg;
    logic              sample_rej;
    logic              locked;
    logic [3:0]        fill_cnt;
    logic [7:0]        reject_cnt;
`ifdef DOA_FILTER_SEG_EN
    logic [6:0]        seg2, seg1, seg0;
`endif

    doa_filter #(.DEPTH(DEPTH), .MAX_STEP(MAX_STEP), .REJ_LIMIT(REJ_LIMIT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .doa_in     (doa_in),
        .clear      (clear),
        .out_valid  (out_valid),
        .doa_avg    (doa_avg),
        .sample_rej (sample_rej),
        .locked     (locked),
        .fill_cnt   (fill_cnt),
        .reject_cnt (reject_cnt)
`ifdef DOA_FILTER_SEG_EN
        ,
        .seg2       (seg2),
        .seg1       (seg1),
        .seg0       (seg0)
`endif
    );

    always #10 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state
    int q[$];
    int m_avg    = 0;
    int m_consec = 0;
    int m_rc     = 0;
    int m_rej    = 0;

    task automatic check_eq(input string tag, input logic signed [31:0] got,
                            input logic signed [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int floor_div(input int n, input int d);
        int r;
        r = n / d;
        if ((n % d != 0) && (n < 0)) r = r - 1;
        return r;
    endfunction

    function automatic int iabs(input int x);
        return (x < 0) ? -x : x;
    endfunction

    task automatic model_reset(input bit full);
        q.delete();
        m_avg    = 0;
        m_consec = 0;
        if (full) begin
            m_rc  = 0;
            m_rej = 0;
        end
    endtask

    task automatic model_step(input int v);
        bit rng_bad, outl;
        int s;
        rng_bad = (v < -90) || (v > 90);
        outl    = (q.size() == DEPTH) && (iabs(v - m_avg) > MAX_STEP);
        if (!rng_bad && outl && (m_consec + 1 >= REJ_LIMIT)) begin
            q.delete();
            q.push_back(v);
            m_avg    = v;
            m_consec = 0;
            m_rej    = 0;
        end else if (rng_bad || outl) begin
            if (m_rc < 255) m_rc++;
            if (!rng_bad) m_consec++;
            m_rej = 1;
        end else begin
            q.push_back(v);
            if (q.size() > DEPTH) void'(q.pop_front());
            m_consec = 0;
            m_rej    = 0;
            if (q.size() == DEPTH) begin
                s = 0;
                foreach (q[i]) s += q[i];
                m_avg = floor_div(s + DEPTH / 2, DEPTH);
            end else begin
                m_avg = v;
            end
        end
    endtask

`ifdef DOA_FILTER_SEG_EN
    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
            4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
            8: return 7'h00;  9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction
`endif

    task automatic check_outputs(input string tag);
        check_eq({tag, "_avg"},    32'(doa_avg), m_avg);
        check_eq({tag, "_rej"},    32'(sample_rej), m_rej);
        check_eq({tag, "_fill"},   32'(fill_cnt), q.size());
        check_eq({tag, "_locked"}, 32'(locked), (q.size() == DEPTH) ? 1 : 0);
        check_eq({tag, "_rcnt"},   32'(reject_cnt), m_rc);
    endtask

    // One sample through the pipeline, five cycles per call.
    task automatic send(input int v, input string tag);
        @(posedge clk); #1;
        in_valid = 1'b1;
        doa_in   = 8'(v);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_eq({tag, "_ov_s1"}, 32'(out_valid), 0);
        @(posedge clk); #1;
        check_eq({tag, "_ov"}, 32'(out_valid), 1);
        model_step(v);
        check_outputs(tag);
        @(posedge clk); #1;
        check_eq({tag, "_ov_drop"}, 32'(out_valid), 0);
`ifdef DOA_FILTER_SEG_EN
        check_eq({tag, "_seg2"}, 32'(seg2), (m_avg < 0) ? 32'h3F : 32'h7F);
        check_eq({tag, "_seg1"}, 32'(seg1), 32'(seg_of(iabs(m_avg) / 10)));
        check_eq({tag, "_seg0"}, 32'(seg0), 32'(seg_of(iabs(m_avg) % 10)));
`endif
        @(posedge clk);
    endtask

    task automatic do_clear();
        @(posedge clk); #1;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        model_reset(1'b0);
        check_eq("clr_fill", 32'(fill_cnt), 0);
        check_eq("clr_locked", 32'(locked), 0);
        check_eq("clr_avg", 32'(doa_avg), 0);
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_ov"},     32'(out_valid), 0);
        check_eq({tag, "_avg"},    32'(doa_avg), 0);
        check_eq({tag, "_rej"},    32'(sample_rej), 0);
        check_eq({tag, "_locked"}, 32'(locked), 0);
        check_eq({tag, "_fill"},   32'(fill_cnt), 0);
        check_eq({tag, "_rcnt"},   32'(reject_cnt), 0);
`ifdef DOA_FILTER_SEG_EN
        check_eq({tag, "_seg2"}, 32'(seg2), 32'h7F);
        check_eq({tag, "_seg1"}, 32'(seg1), 32'h7F);
        check_eq({tag, "_seg0"}, 32'(seg0), 32'h7F);
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int v;
        // Reset
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check_reset_state("rst");

        // Window fill
        for (int i = 0; i < DEPTH; i++) begin
            send(30, "fill");
            check_eq("fill_cnt_seq", 32'(fill_cnt), i + 1);
        end
        check_eq("fill_locked", 32'(locked), 1);

        // Boundary accept: |0-30| == MAX_STEP
        send(0, "bnd");
        check_eq("bnd_avg_const", 32'(doa_avg), 26);

        // Outlier and re-seed
        do_clear();
        for (int i = 0; i < DEPTH; i++) send(30, "refill");
        for (int i = 0; i < 3; i++) begin
            send(-60, "outl");
            check_eq("outl_avg_const", 32'(doa_avg), 30);
            check_eq("outl_rcnt_const", 32'(reject_cnt), i + 1);
        end
        send(-60, "reseed");
        check_eq("reseed_avg_const", 32'(doa_avg), -60);
        check_eq("reseed_fill_const", 32'(fill_cnt), 1);
        check_eq("reseed_locked_const", 32'(locked), 0);
        check_eq("reseed_rcnt_const", 32'(reject_cnt), 3);

        // Range check in FILL
        send(100, "range");
        check_eq("range_rej_const", 32'(sample_rej), 1);
        check_eq("range_rcnt_const", 32'(reject_cnt), 4);
        check_eq("range_fill_const", 32'(fill_cnt), 1);

        // Negative rounding
        do_clear();
        for (int i = 0; i < DEPTH; i++) send(-60, "neg");
        check_eq("neg_avg_const", 32'(doa_avg), -60);
        send(-59, "neg59");
        check_eq("neg59_avg_const", 32'(doa_avg), -60);

        // clear together with in_valid
        @(posedge clk); #1;
        in_valid = 1'b1; clear = 1'b1; doa_in = 8'sd20;
        @(posedge clk); #1;
        in_valid = 1'b0; clear = 1'b0;
        model_reset(1'b0);
        for (int i = 0; i < 3; i++) begin
            check_eq("coll_ov", 32'(out_valid), 0);
            @(posedge clk); #1;
        end
        check_eq("coll_fill", 32'(fill_cnt), 0);
        check_eq("coll_locked", 32'(locked), 0);

        // clear while a sample is in S1
        @(posedge clk); #1;
        in_valid = 1'b1; doa_in = 8'sd15;
        @(posedge clk); #1;
        in_valid = 1'b0; clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        check_eq("abort_ov0", 32'(out_valid), 0);
        @(posedge clk); #1;
        check_eq("abort_ov1", 32'(out_valid), 0);
        check_eq("abort_fill", 32'(fill_cnt), 0);

        // Back-to-back in_valid: only the first is taken
        @(posedge clk); #1;
        in_valid = 1'b1; doa_in = 8'sd40;
        @(posedge clk); #1;
        doa_in = -8'sd40;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_eq("b2b_ov", 32'(out_valid), 1);
        model_step(40);
        check_outputs("b2b");
        @(posedge clk); #1;
        check_eq("b2b_ov_second0", 32'(out_valid), 0);
        @(posedge clk); #1;
        check_eq("b2b_ov_second1", 32'(out_valid), 0);
        check_eq("b2b_fill", 32'(fill_cnt), 1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 4) begin
                do_clear();
            end else begin
                if (r < 22) v = int'($urandom_range(0, 255)) - 128;
                else        v = m_avg + int'($urandom_range(0, 70)) - 35;
                if (v > 127)  v = 127;
                if (v < -128) v = -128;
                send(v, "rnd");
            end
        end

        // reject_cnt saturation
        for (int i = 0; i < 260; i++) send((i % 2 == 0) ? 100 : -128, "sat");
        check_eq("sat_rcnt_const", 32'(reject_cnt), 255);

        // Reset with a sample in flight
        @(posedge clk); #1;
        in_valid = 1'b1; doa_in = 8'sd10;
        @(posedge clk); #1;
        in_valid = 1'b0; rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset(1'b1);
        check_reset_state("midrst");
        @(posedge clk); #1;
        check_eq("midrst_ov_late", 32'(out_valid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/doa_filter.md
Name: doa_filter

Overview:
- Post-processing stage directly downstream of the weight block. It consumes the per-frame direction-of-arrival estimate (doa, degrees -90..90) and its done pulse.
- Produces a temporally smoothed DOA: a moving average over DEPTH accepted frames, with range and outlier rejection and fast re-acquisition after a genuine source jump.
- One instance per axis (X, Y); the outputs feed the Avalon readback and the 7-seg displays.

Parameters:
- DEPTH, 8, averaging window length in frames; power of 2, minimum 2.
- MAX_STEP, 30, maximum allowed |doa_in - doa_avg| in degrees for a sample to be accepted while LOCKED.
- REJ_LIMIT, 4, consecutive outlier rejections that force a flush and re-seed.

Ports:
- clk  in  1  system clock, 50 MHz
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  one-cycle pulse; doa_in valid (weight-block done)
- doa_in  in  8  signed two's-complement DOA estimate
- clear  in  1  synchronous flush of the filter, level-sensitive
- out_valid  out  1  one-cycle pulse; doa_avg and flags updated
- doa_avg  out  8  signed smoothed DOA
- sample_rej  out  1  qualified by out_valid; the last sample was rejected
- locked  out  1  window full (state LOCKED)
- fill_cnt  out  $clog2(DEPTH)+1  number of valid window entries, 0..DEPTH
- reject_cnt  out  8  total rejections, saturating at 255

Behaviour:
- Reset (rst_n=0 at posedge): every output is 0, state EMPTY, write pointer 0, sum 0, consecutive-reject count 0. Window contents are don't-care; they are never read before being written.
- States and transitions:
  - EMPTY: first accepted sample goes to FILL.
  - FILL: goes to LOCKED when fill_cnt reaches DEPTH.
  - LOCKED: a flush goes to FILL with fill_cnt=1.
- Pipeline:
  - S1 (cycle after in_valid): register doa_in and compute the accept/reject decision.
  - S2: update the window, sum and pointer, and compute the average.
  - out_valid pulses 2 cycles after in_valid; doa_avg and the flags change in that same cycle.
- Busy: in_valid arriving while S1 or S2 is occupied is ignored. No counter changes and no out_valid is produced for it.
- Range check, applied in every state: doa_in < -90 or > 90 is rejected.
  - reject_cnt increments; the consecutive count is unchanged.
  - doa_avg holds; sample_rej=1.
- Outlier check, applied only in LOCKED: |doa_in - doa_avg| > MAX_STEP, computed at 9-bit signed width, is rejected.
  - reject_cnt and the consecutive count both increment.
- Flush: when the consecutive count reaches REJ_LIMIT, that sample is not treated as rejected.
  - The window is flushed and this sample seeds it: sum=doa_in, fill_cnt=1, pointer=1, state FILL.
  - doa_avg=doa_in; sample_rej=0; the consecutive count clears.
- Accept path:
  - Write buf[ptr]; ptr wraps modulo DEPTH.
  - sum += doa_in - (locked ? buf[ptr] : 0). sum is signed, 8+$clog2(DEPTH) bits.
  - fill_cnt saturates at DEPTH. The consecutive count clears.
- Output value:
  - In FILL, doa_avg = the newest accepted sample (pass-through).
  - On entering LOCKED and while LOCKED, doa_avg = (sum + DEPTH/2) >>> $clog2(DEPTH), i.e. arithmetic shift with round-half-up.
- reject_cnt saturates at 255 and is not cleared by clear.
- clear:
  - Returns the block to EMPTY and zeroes fill_cnt, sum, pointer, doa_avg, locked and the consecutive count.
  - It aborts any in-flight S1/S2, so no out_valid is produced.
  - It has priority over a simultaneous in_valid, which is discarded.
- rst_n low mid-pipeline: the in-flight sample is discarded and all outputs return to reset values.

Optional Feature:
- Macro DOA_FILTER_SEG_EN.
- Defined: adds outputs seg2, seg1, seg0 (7 bits each, active-low segments).
  - seg2 shows '-' when doa_avg is negative, else blank.
  - seg1 shows the tens digit; seg0 shows the ones digit of |doa_avg|.
  - The seg outputs are registered and update one cycle after out_valid. Reset value is blank (7'h7F).
- Undefined: the ports and the decoder logic are absent; behaviour is otherwise identical.

Decomposition:
- Package doa_filter_pkg:
  - state enum (EMPTY, FILL, LOCKED);
  - DOA_MIN=-90, DOA_MAX=90;
  - 7-seg constants for digits 0-9, minus and blank.
- Sub-module seg7_digit: 4-bit digit in, 7-bit active-low pattern out. Instantiated only under DOA_FILTER_SEG_EN.

Test Plan:
- Window fill: reset, then 8 pulses of doa_in=30 spaced 5 cycles apart.
  - out_valid at in_valid+2 each time; doa_avg=30 throughout.
  - fill_cnt 1..8; locked=1 after the 8th.
- Boundary accept: LOCKED at 30, feed 0 (|diff|=30, not >30).
  - Accepted; sum=210, so doa_avg=(210+4)>>>3=26; sample_rej=0.
- Outlier and re-seed: LOCKED at 30, feed -60 four times.
  - First 3: sample_rej=1, doa_avg=30, reject_cnt=1,2,3.
  - 4th: flush; doa_avg=-60, fill_cnt=1, locked=0, reject_cnt=3.
- Range check: in FILL, feed 100.
  - sample_rej=1, reject_cnt+1, fill_cnt unchanged, consecutive count unchanged.
- Negative rounding: 8×-60 gives doa_avg=-60. Then feed -59 once, giving sum=-479 and doa_avg=(-475)>>>3=-60.
- Collisions:
  - clear together with in_valid: no out_valid; fill_cnt=0; state EMPTY.
  - Back-to-back in_valid on consecutive cycles: only the first produces out_valid; the second is ignored.
